// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receiver state encoding, channel codes and default frame geometry.
package i2s_pkg;

    localparam int unsigned I2S_DATA_WIDTH = 24;
    localparam int unsigned I2S_SLOT_WIDTH = 32;

    localparam logic I2S_LEFT  = 1'b0;
    localparam logic I2S_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_rx_state_t;

endpackage

// File: rtl/i2s_frame_holder.sv
// Valid/ready output register for one stereo frame.
// A commit while the held frame is still unaccepted is dropped and flagged.
module i2s_frame_holder
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = I2S_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  commit,
    input  logic [DATA_WIDTH-1:0] left_word,
    input  logic [DATA_WIDTH-1:0] right_word,
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] left_sample,
    output logic [DATA_WIDTH-1:0] right_sample,
    output logic                  valid,
    output logic                  overrun
);

    // A commit on the same edge as a transfer reloads and keeps valid high
    always_ff @(posedge clk) begin
        if (reset) begin
            left_sample  <= '0;
            right_sample <= '0;
            valid        <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (commit) begin
                if (!valid || ready) begin
                    left_sample  <= left_word;
                    right_sample <= right_word;
                    valid        <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/i2s_receiver.sv
// I2S deserializer: tracks frame alignment from word_select, captures MSB-first words
// and hands completed left/right pairs to the frame holder.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = I2S_DATA_WIDTH,
    parameter int unsigned SLOT_WIDTH = I2S_SLOT_WIDTH
) (
    input  logic                          serial_clk,
    input  logic                          reset,
    input  logic                          word_select,
    input  logic                          sound_bit_in,
    output logic [DATA_WIDTH-1:0]         left_sample,
    output logic [DATA_WIDTH-1:0]         right_sample,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic                          overrun,
    output logic                          frame_error,
    output logic [$clog2(SLOT_WIDTH)-1:0] bit_counter
);

    localparam int unsigned CW = $clog2(SLOT_WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(SLOT_WIDTH - 1);
    localparam logic [CW-1:0] DONE_IDX = CW'(DATA_WIDTH - 1);

    i2s_rx_state_t         state;
    i2s_rx_state_t         state_next_c;
    logic                  ws_q;
    logic                  ws_change_c;
    logic                  err_c;
    logic                  capture_c;
    logic                  left_load_c;
    logic                  commit_c;
    logic [CW-1:0]         cnt_next_c;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_next_c;
    logic [DATA_WIDTH-1:0] left_stage_q;

    assign ws_change_c  = word_select != ws_q;
    assign shift_next_c = DATA_WIDTH'({shift_q, sound_bit_in});

    always_ff @(posedge serial_clk) begin
        if (reset) begin
            state <= SYNC;
        end else begin
            state <= state_next_c;
        end
    end

    // A right slot is never entered without its left word, so mid-slot errors toward right resync
    always_comb begin
        state_next_c = state;
        unique case (state)
            SYNC: begin
                if (ws_q == I2S_RIGHT && word_select == I2S_LEFT) begin
                    state_next_c = LEFT;
                end
            end
            LEFT, RIGHT: begin
                if (ws_change_c) begin
                    if (bit_counter == LAST_IDX) begin
                        state_next_c = (state == LEFT) ? RIGHT : LEFT;
                    end else begin
                        state_next_c = (word_select == I2S_RIGHT) ? SYNC : LEFT;
                    end
                end else if (bit_counter == LAST_IDX) begin
                    state_next_c = SYNC;
                end
            end
            default: state_next_c = SYNC;
        endcase
    end

    // Slot is well formed only when the WS edge lands exactly on the last slot bit
    always_comb begin
        err_c       = 1'b0;
        capture_c   = 1'b0;
        left_load_c = 1'b0;
        commit_c    = 1'b0;
        cnt_next_c  = '0;
        if (state != SYNC) begin
            err_c     = ws_change_c != (bit_counter == LAST_IDX);
            capture_c = 32'(bit_counter) < DATA_WIDTH;
            if (!ws_change_c && bit_counter != LAST_IDX) begin
                cnt_next_c = bit_counter + CW'(1);
            end
            if (bit_counter == DONE_IDX && !err_c) begin
                left_load_c = state == LEFT;
                commit_c    = state == RIGHT;
            end
        end
    end

    always_ff @(posedge serial_clk) begin
        if (reset) begin
            ws_q         <= 1'b1;
            bit_counter  <= '0;
            shift_q      <= '0;
            left_stage_q <= '0;
            frame_error  <= 1'b0;
        end else begin
            ws_q        <= word_select;
            bit_counter <= cnt_next_c;
            frame_error <= err_c;
            if (capture_c) begin
                shift_q <= shift_next_c;
            end
            if (left_load_c) begin
                left_stage_q <= shift_next_c;
            end
        end
    end

    i2s_frame_holder #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_holder (
        .clk         (serial_clk),
        .reset       (reset),
        .commit      (commit_c),
        .left_word   (left_stage_q),
        .right_word  (shift_next_c),
        .ready       (sample_ready),
        .left_sample (left_sample),
        .right_sample(right_sample),
        .valid       (sample_valid),
        .overrun     (overrun)
    );

endmodule

// File: tb/tb_i2s_receiver.sv
// Scoreboard bench for i2s_receiver: two instances (24/32 and 16/32) fed with scripted
// and random I2S streams; a monitor checks every handshake transfer against expected frames.
module tb_i2s_receiver;

    typedef struct {
        bit          ws;
        bit          sd;
        bit          rdy;
        bit          rst;
        bit          commit;
        logic [23:0] el;
        logic [23:0] er;
    } ent_t;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        int          cyc_n;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        ws_in[2], sd_in[2], rdy_in[2], rst_in[2];
    logic [23:0] lo[2], ro[2];
    logic        vld[2], ov[2], fe[2];
    logic [4:0]  bc[2];

    logic [23:0] lo0, ro0;
    logic [15:0] lo1, ro1;
    logic        v0, v1, o0, o1, f0, f1;
    logic [4:0]  b0, b1;

    i2s_receiver #(.DATA_WIDTH(24), .SLOT_WIDTH(32)) dut0 (
        .serial_clk(clk), .reset(rst_in[0]), .word_select(ws_in[0]), .sound_bit_in(sd_in[0]),
        .left_sample(lo0), .right_sample(ro0), .sample_valid(v0), .sample_ready(rdy_in[0]),
        .overrun(o0), .frame_error(f0), .bit_counter(b0)
    );

    i2s_receiver #(.DATA_WIDTH(16), .SLOT_WIDTH(32)) dut1 (
        .serial_clk(clk), .reset(rst_in[1]), .word_select(ws_in[1]), .sound_bit_in(sd_in[1]),
        .left_sample(lo1), .right_sample(ro1), .sample_valid(v1), .sample_ready(rdy_in[1]),
        .overrun(o1), .frame_error(f1), .bit_counter(b1)
    );

    assign lo[0] = lo0;
    assign ro[0] = ro0;
    assign lo[1] = {8'h00, lo1};
    assign ro[1] = {8'h00, ro1};
    assign vld[0] = v0;
    assign vld[1] = v1;
    assign ov[0] = o0;
    assign ov[1] = o1;
    assign fe[0] = f0;
    assign fe[1] = f1;
    assign bc[0] = b0;
    assign bc[1] = b1;

    ent_t        stim[2][$];
    exp_t        sb[2][$];
    int          exp_ov[2], exp_fe[2], got_ov[2], got_fe[2];
    int          n_chk, n_fail, cyc;
    bit          prev_bit[2];
    logic [23:0] last_l[2], last_r[2];
    logic        last_v[2];
    int          held_vis[2];

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d] at cycle %0d: actual=%0h required=%0h", name, i, cyc, act, exp);
        end
    endtask

    // Slot bit p sits at bits[31-p]; bits below the data word are random padding
    function automatic logic [31:0] pack_word(input int dw, input logic [23:0] v);
        logic [31:0] pad_mask;
        pad_mask = (32'd1 << (32 - dw)) - 32'd1;
        return (32'(v) << (32 - dw)) | (32'($urandom) & pad_mask);
    endfunction

    task automatic add_slot(input int i, input bit ws, input logic [31:0] bits, input int len, input bit rdy);
        ent_t e;
        for (int p = 0; p < len; p++) begin
            e.ws     = ws;
            e.sd     = (p < 32) ? bits[31 - p] : 1'($urandom);
            e.rdy    = rdy;
            e.rst    = 1'b0;
            e.commit = 1'b0;
            e.el     = '0;
            e.er     = '0;
            stim[i].push_back(e);
        end
    endtask

    task automatic add_reset(input int i, input int n);
        ent_t e;
        for (int p = 0; p < n; p++) begin
            e.ws = 1'b1; e.sd = 1'b0; e.rdy = 1'b1; e.rst = 1'b1;
            e.commit = 1'b0; e.el = '0; e.er = '0;
            stim[i].push_back(e);
        end
    endtask

    // Right bit dw-1 is sampled one edge after its slot position, i.e. at slot entry dw
    task automatic add_frame(input int i, input int dw, input logic [23:0] l, input logic [23:0] r,
                             input bit rdy_body, input bit rdy_commit, input bit accept);
        logic [23:0] m;
        int          base;
        ent_t        e;
        m = (24'd1 << dw) - 24'd1;
        add_slot(i, 1'b0, pack_word(dw, l & m), 32, rdy_body);
        base = stim[i].size();
        add_slot(i, 1'b1, pack_word(dw, r & m), 32, rdy_body);
        e = stim[i][base + dw];
        e.rdy    = rdy_commit;
        e.commit = accept;
        e.el     = l & m;
        e.er     = r & m;
        stim[i][base + dw] = e;
        if (!accept) exp_ov[i]++;
    endtask

    task automatic drive_one(input int i);
        ent_t e;
        exp_t x;
        if (stim[i].size() > 0) begin
            e = stim[i].pop_front();
            ws_in[i]    = e.ws;
            sd_in[i]    = prev_bit[i];
            prev_bit[i] = e.sd;
            rdy_in[i]   = e.rdy;
            rst_in[i]   = e.rst;
            if (e.commit) begin
                x.l = e.el; x.r = e.er; x.cyc_n = cyc + 1;
                sb[i].push_back(x);
            end
        end else begin
            ws_in[i] = 1'b1; sd_in[i] = 1'b0; rdy_in[i] = 1'b1; rst_in[i] = 1'b1;
            prev_bit[i] = 1'b0;
        end
    endtask

    // Monitor: a transfer at edge n is valid(before n) && ready(at n)
    always @(posedge clk) begin
        bit   xfer;
        exp_t x;
        cyc++;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rst_in[i]) begin
                check("reset_valid", i, 32'(vld[i]), 32'd0);
                check("reset_left", i, 32'(lo[i]), 32'd0);
                check("reset_right", i, 32'(ro[i]), 32'd0);
                check("reset_overrun", i, 32'(ov[i]), 32'd0);
                check("reset_frame_error", i, 32'(fe[i]), 32'd0);
                check("reset_bit_counter", i, 32'(bc[i]), 32'd0);
                last_v[i] = 1'b0;
            end else begin
                xfer = last_v[i] && rdy_in[i];
                if (xfer) begin
                    if (sb[i].size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_frame[dut%0d] at cycle %0d: actual=%0h/%0h required=none",
                                 i, cyc, last_l[i], last_r[i]);
                    end else begin
                        x = sb[i].pop_front();
                        check("left_sample", i, 32'(last_l[i]), 32'(x.l));
                        check("right_sample", i, 32'(last_r[i]), 32'(x.r));
                        check("valid_latency_cycle", i, 32'(held_vis[i]), 32'(x.cyc_n));
                    end
                end
                if (last_v[i] && !rdy_in[i]) begin
                    check("stall_valid", i, 32'(vld[i]), 32'd1);
                    check("stall_left", i, 32'(lo[i]), 32'(last_l[i]));
                    check("stall_right", i, 32'(ro[i]), 32'(last_r[i]));
                end
                if (vld[i] && (!last_v[i] || xfer)) held_vis[i] = cyc;
                if (ov[i]) got_ov[i]++;
                if (fe[i]) got_fe[i]++;
                last_v[i] = vld[i];
                last_l[i] = lo[i];
                last_r[i] = ro[i];
            end
        end
    end

    initial begin
        int base;
        ent_t e;
        for (int i = 0; i < 2; i++) begin
            ws_in[i] = 1'b1; sd_in[i] = 1'b0; rdy_in[i] = 1'b1; rst_in[i] = 1'b1;
            prev_bit[i] = 1'b0; last_v[i] = 1'b0; held_vis[i] = 0;
            exp_ov[i] = 0; exp_fe[i] = 0; got_ov[i] = 0; got_fe[i] = 0;
        end
        n_chk = 0; n_fail = 0; cyc = 0;

        // Instance 0: start-up garbage mid right slot, then clean frames
        add_reset(0, 4);
        add_slot(0, 1'b1, $urandom, 13, 1'b1);
        for (int k = 0; k < 4; k++) add_frame(0, 24, 24'hA5A5A5, 24'h5A5A5A, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) add_frame(0, 24, 24'($urandom), 24'($urandom), 1'b1, 1'b1, 1'b1);
        // Backpressure: held, dropped, released; then a transfer coinciding with a commit
        add_frame(0, 24, 24'h111111, 24'h222222, 1'b0, 1'b0, 1'b1);
        add_frame(0, 24, 24'h333333, 24'h444444, 1'b0, 1'b0, 1'b0);
        add_frame(0, 24, 24'h555555, 24'h666666, 1'b1, 1'b1, 1'b1);
        add_frame(0, 24, 24'h777777, 24'h888888, 1'b0, 1'b0, 1'b1);
        add_frame(0, 24, 24'h999999, 24'hAAAAAA, 1'b0, 1'b1, 1'b1);
        add_frame(0, 24, 24'($urandom), 24'($urandom), 1'b1, 1'b1, 1'b1);
        // Short left slot: WS flips at count 20, toward right -> resync
        add_slot(0, 1'b0, $urandom, 21, 1'b1);
        add_slot(0, 1'b1, $urandom, 32, 1'b1);
        exp_fe[0]++;
        add_frame(0, 24, 24'h000001, 24'h800000, 1'b1, 1'b1, 1'b1);
        // Long left slot: no WS change at the last slot bit
        add_slot(0, 1'b0, $urandom, 40, 1'b1);
        add_slot(0, 1'b1, $urandom, 32, 1'b1);
        exp_fe[0]++;
        add_frame(0, 24, 24'($urandom), 24'($urandom), 1'b1, 1'b1, 1'b1);
        // Reset on the edge sampling left bit 10; WS low after reset looks like a falling
        // edge, so the truncated slot then ends early (count 19) and flags one error
        base = stim[0].size();
        add_slot(0, 1'b0, $urandom, 32, 1'b1);
        e = stim[0][base + 11];
        e.rst = 1'b1;
        stim[0][base + 11] = e;
        add_slot(0, 1'b1, $urandom, 32, 1'b1);
        exp_fe[0]++;
        add_frame(0, 24, 24'hC0FFEE, 24'h0BADF0, 1'b1, 1'b1, 1'b1);
        add_frame(0, 24, 24'($urandom), 24'($urandom), 1'b1, 1'b1, 1'b1);
        add_slot(0, 1'b0, $urandom, 4, 1'b1);

        // Instance 1: 16-bit words in 32-bit slots, padding bits ignored
        add_reset(1, 4);
        add_slot(1, 1'b1, $urandom, 7, 1'b1);
        add_frame(1, 16, 24'h001234, 24'h00FEDC, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) add_frame(1, 16, 24'($urandom), 24'($urandom), 1'b1, 1'b1, 1'b1);
        add_frame(1, 16, 24'h000000, 24'h00FFFF, 1'b1, 1'b1, 1'b1);
        add_slot(1, 1'b0, $urandom, 4, 1'b1);

        for (int k = 0; k < 20000; k++) begin
            if (stim[0].size() == 0 && stim[1].size() == 0) break;
            @(negedge clk);
            drive_one(0);
            drive_one(1);
        end
        if (stim[0].size() != 0 || stim[1].size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL stimulus_timeout: remaining=%0d/%0d required=0", stim[0].size(), stim[1].size());
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_one(0);
            drive_one(1);
        end
        @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            check("frames_not_delivered", i, 32'(sb[i].size()), 32'd0);
            check("overrun_pulses", i, 32'(got_ov[i]), 32'(exp_ov[i]));
            check("frame_error_pulses", i, 32'(got_fe[i]), 32'(exp_fe[i]));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_receiver.md
# i2s_receiver

I2S serial-to-parallel receiver that consumes the bit stream produced by the board's I2S transmitter (loopback and ADC path) and presents one stereo sample pair per frame on a valid/ready interface. It runs in the serial-clock domain, tracks frame alignment from `word_select`, and flags slot-length errors and consumer overruns. It sits between the I2S pins and the audio processing pipeline.

## Interface
- `DATA_WIDTH`, default 24: sample bits captured per channel, MSB-first; must be ≤ `SLOT_WIDTH`.
- `SLOT_WIDTH`, default 32: serial clocks per channel slot; must be a power of two ≥ 8.
- `serial_clk`  in  1: I2S bit clock, the only clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `word_select`  in  1: I2S WS; 0 = left, 1 = right.
- `sound_bit_in`  in  1: I2S serial data.
- `left_sample`  out  DATA_WIDTH: left word of the held frame.
- `right_sample`  out  DATA_WIDTH: right word of the held frame.
- `sample_valid`  out  1: held frame is available.
- `sample_ready`  in  1: consumer accepts the held frame.
- `overrun`  out  1: one-cycle pulse when a completed frame is dropped.
- `frame_error`  out  1: one-cycle pulse on a slot-length violation.
- `bit_counter`  out  $clog2(SLOT_WIDTH): index of the bit captured on the current edge.

## Operation
- `ws_q` registers `word_select` every edge. `ws_change = word_select != ws_q`.
- There are three states:
  - SYNC: the receiver ignores data. A falling WS (`ws_q`=1, `word_select`=0) moves it to LEFT with `bit_counter` reset to 0 on the next edge.
  - LEFT and RIGHT: the edge after a WS change captures bit index 0 (MSB) of the new channel.
- Each edge in LEFT/RIGHT captures `sound_bit_in` into the shift register when `bit_counter` < `DATA_WIDTH`. The receiver discards bits at indices ≥ `DATA_WIDTH`.
- Word completion occurs on the edge that captures index `DATA_WIDTH-1`. In LEFT, the word goes to the left staging register. In RIGHT, the receiver commits the frame (staged left plus the just-completed right word).
- Normal slot end: when `ws_change` is seen at `bit_counter` = `SLOT_WIDTH-1`, that edge captures the LSB-slot bit. The next edge starts the other channel at 0, moving LEFT→RIGHT or RIGHT→LEFT.
- Slot-length violation: `frame_error` pulses and the partial frame is discarded. Two cases trigger it:
  - `ws_change` at any other count: the receiver goes to the channel given by the new WS with counter 0. If the new channel is right, the receiver goes to SYNC instead, because a right word is never committed without its left word.
  - `bit_counter` = `SLOT_WIDTH-1` with no `ws_change`: the receiver goes to SYNC.
- Frame commit rules:
  - If `sample_valid`=0, or `sample_ready`=1 on the same edge, the output registers load and `sample_valid`=1.
  - Otherwise the new frame is dropped, the held frame is kept, and `overrun` pulses.
- Handshake: a transfer occurs on any edge where `sample_valid` and `sample_ready` are both 1. `sample_valid` clears on that edge unless a commit happens on the same edge, in which case it stays 1 and the new data loads.

## Timing
- Reset values:
  - state SYNC, `ws_q`=1.
  - `bit_counter`=0.
  - `left_sample`, `right_sample` = 0.
  - `sample_valid`=0, `overrun`=0, `frame_error`=0.
- Latency: `sample_valid` and the data are visible one cycle after the edge that captures right bit `DATA_WIDTH-1`. That is `SLOT_WIDTH-DATA_WIDTH` serial clocks before the right slot ends.
- `overrun` and `frame_error` are registered single-cycle pulses, asserted in the cycle after the triggering edge.
- Reset mid-frame discards all partial data. The first valid frame requires a fresh falling WS.
- The outputs are stable while `sample_valid`=1 and `sample_ready`=0.

## Structure
- Package `i2s_pkg` holds:
  - state enum `i2s_rx_state_t` (SYNC, LEFT, RIGHT).
  - channel encoding constants `I2S_LEFT`=0, `I2S_RIGHT`=1.
  - default width constants shared with the transmitter.
- There is one sub-module, `i2s_frame_holder`: the valid/ready output register with commit, drop and overrun logic. The deserializer and state machine stay in the top module.

## Test plan
- Clean frames, defaults: left=24'hA5A5A5, right=24'h5A5A5A, `sample_ready`=1. Expected: `sample_valid` high one cycle after right bit 23, data exact, no error pulses, repeated for 4 frames.
- Start-up: stream begins mid-right-slot with garbage. Expected: no `sample_valid` until the first complete left+right frame after a WS falling edge.
- Backpressure: `sample_ready`=0 across 2 frames (1, then 2), then 1. Expected: frame 1 held unchanged, one `overrun` pulse at frame 2's commit, frame 1 transferred when ready rises.
- Short slot: WS toggles at `bit_counter`=20 in the left slot. Expected: one `frame_error` pulse, no output for that frame, next clean frame (left=24'h000001, right=24'h800000) received correctly.
- Reset pulse at left bit 10. Expected: all outputs at reset values the next cycle, the following complete frame received correctly.
- `DATA_WIDTH`=16, `SLOT_WIDTH`=32: left=16'h1234, right=16'hFEDC. Expected: bits 16–31 ignored, exact output.
